reaction_game_ctrl: RTL and testbench
=====================================

# reaction_game_ctrl

Round controller for the keyboard/timer/display datapath: it picks a target letter, arms and runs the centisecond timer that feeds the 14-bit binary-to-BCD converter, and checks decoded keyboard letters against the target. It stops the timer on a correct key and adds a penalty for each wrong key. It also tells the display stage whether to show the target letter or the elapsed time. It sits between the keyboard wrapper output and the bin2bcd/letter7seg display path in the top level.

## Interface
Parameters:
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 100: timer resolution (ticks per second); CLK_HZ/TICK_HZ must be an integer ≥ 2.
- PENALTY, 50: ticks added per wrong key.
- DLY_MIN, 100: minimum random arm delay in ticks.
- LFSR_SEED, 16'hACE1: reset value of the internal LFSR; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  debounced start button, level; only its rising edge is used.
- key_valid  in  1  one-cycle strobe: a new letter is on key_code.
- key_code  in  4  decoded letter index from the keyboard wrapper.
- target  out  4  letter the player must type.
- timer_out  out  14  elapsed ticks, binary, to bin2bcd; saturates at 9999.
- show_time  out  1  1 = display timer_out digits, 0 = display target.
- busy  out  1  high in ARM and RUN.
- done  out  1  high in DONE.
- false_start  out  1  set by a key during ARM; cleared by the next start.
- miss_cnt  out  4  count of wrong keys this round; saturates at 15.

## Operation
- Tick prescaler: a counter wraps every CLK_HZ/TICK_HZ cycles and emits a one-cycle tick. It is cleared on every state entry.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. It advances every clk and is never cleared except by reset.
- States are IDLE, ARM, RUN and DONE. Reset enters IDLE.
- IDLE: show_time=0. On the rising edge of start:
  - target ← lfsr[3:0]
  - delay ← DLY_MIN + lfsr[11:4]
  - timer_out ← 0, miss_cnt ← 0, false_start ← 0
  - go to ARM.
- ARM: show_time=0 and target is displayed. Each tick decrements delay. When delay reaches 0, go to RUN. If key_valid occurs in ARM, set false_start=1, go to IDLE and leave timer_out at 0.
- RUN:
  - Each tick increments timer_out, saturating at 9999.
  - key_valid with key_code==target: go to DONE.
  - key_valid with key_code≠target: timer_out ← min(timer_out+PENALTY, 9999) and miss_cnt increments, saturating at 15.
- DONE: show_time=1 and timer_out is frozen. A start rising edge begins a new round exactly as from IDLE.
- A start edge while in ARM or RUN is ignored.
- key_valid is ignored in IDLE and DONE.

## Timing
- All outputs are registered. Reset values:
  - target=0, timer_out=0, show_time=0
  - busy=0, done=0, false_start=0, miss_cnt=0.
- Start edge detection uses one registered copy of start. ARM is entered in the cycle after the sampled edge, and busy rises in that same cycle.
- A correct key at cycle n makes done=1 and show_time=1 at n+1. timer_out stays at its value from before cycle n.
- If a tick and a correct key_valid occur in the same cycle, the tick is discarded.
- If a tick and a wrong key occur in the same cycle: timer_out ← min(timer_out+1+PENALTY, 9999).
- A tick and a key_valid in the same ARM cycle count as a false start; the delay does not expire.
- When delay expires, RUN starts with the prescaler cleared. The first increment comes CLK_HZ/TICK_HZ cycles after RUN entry.
- Reset asserted mid-round forces all reset values immediately, asynchronously.

## Structure
- A shared package holds:
  - the state enum (IDLE, ARM, RUN, DONE)
  - TIME_MAX=9999, TIME_W=14, LETTER_W=4.
- One sub-module, tick_gen: the prescaler with a clear input and a tick output, parameterised by CLK_HZ and TICK_HZ.
- The LFSR, FSM and timer arithmetic stay in the top of this block.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), DLY_MIN=2.

- Reset with no stimulus: all outputs 0, state IDLE, busy=0 held for 1000 cycles.
- Start edge, wait for RUN, then 37 ticks, then key_code=target: done=1 next cycle, timer_out=37, show_time=1, miss_cnt=0.
- In RUN at timer_out=10, send two wrong keys then the correct key: miss_cnt=2, timer_out=110 plus any ticks elapsed in between.
- Any key during ARM: false_start=1, state IDLE, timer_out=0. The next start clears false_start.
- Preload via 9990 ticks plus a wrong key: timer_out=9999, and it stays 9999 on further ticks.
- Correct key coincident with a tick at timer_out=5: timer_out=5. rst_n pulsed low in RUN: all outputs return to 0 immediately.

Source files
------------

// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and constants for the reaction-game round controller.
// Holds the round state encoding and the saturating timer add.
package reaction_game_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned TIME_MAX = 9999;
    localparam int          TIME_W   = 14;
    localparam int          LETTER_W = 4;

    // Adds inc to a timer value, clamping at the largest displayable time.
    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                  input int unsigned       inc);
        int unsigned s;
        s = 32'(t) + inc;
        return (s > TIME_MAX) ? TIME_W'(TIME_MAX) : TIME_W'(s);
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ cycles, restartable by clr.
// Tick is a decode of the counter register; no backpressure.
module reaction_game_ctrl_tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game round controller: random target/arm delay, centisecond timer, key checking.
// All outputs registered (one cycle after the deciding input); no backpressure, key strobes are never stalled.
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TICK_HZ   = 100,
    parameter int unsigned PENALTY   = 50,
    parameter int          DLY_MIN   = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_code,
    output logic [LETTER_W-1:0] target,
    output logic [TIME_W-1:0]   timer_out,
    output logic                show_time,
    output logic                busy,
    output logic                done,
    output logic                false_start,
    output logic [3:0]          miss_cnt
);

    localparam int DLY_W = $clog2(DLY_MIN + 256) + 1;

    state_t              state, state_nxt;
    logic [15:0]         lfsr;
    logic                start_q;
    logic                start_rise;
    logic                tick;
    logic                tick_clr;
    logic [DLY_W-1:0]    delay, delay_nxt;
    logic [LETTER_W-1:0] target_nxt;
    logic [TIME_W-1:0]   timer_nxt;
    logic [3:0]          miss_nxt;
    logic                fs_nxt;

    assign start_rise = start & ~start_q;
    // Every state change restarts the prescaler so each phase sees full tick periods.
    assign tick_clr   = (state_nxt != state);

    reaction_game_ctrl_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        delay_nxt  = delay;
        timer_nxt  = timer_out;
        miss_nxt   = miss_cnt;
        fs_nxt     = false_start;
        case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    target_nxt = lfsr[3:0];
                    delay_nxt  = DLY_W'(DLY_MIN) + DLY_W'(lfsr[11:4]);
                    timer_nxt  = '0;
                    miss_nxt   = '0;
                    fs_nxt     = 1'b0;
                    state_nxt  = ARM;
                end
            end
            ARM: begin
                // A key beats a coincident tick, so the delay cannot expire that cycle.
                if (key_valid) begin
                    fs_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (delay <= DLY_W'(1)) begin
                        state_nxt = RUN;
                    end
                    delay_nxt = (delay == '0) ? '0 : delay - DLY_W'(1);
                end
            end
            RUN: begin
                if (key_valid && (key_code == target)) begin
                    state_nxt = DONE;
                end else begin
                    timer_nxt = sat_add(timer_out,
                                        32'(tick) + (key_valid ? PENALTY : 32'd0));
                    if (key_valid && (miss_cnt != 4'hF)) begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            start_q     <= 1'b0;
            delay       <= '0;
            target      <= '0;
            timer_out   <= '0;
            miss_cnt    <= '0;
            false_start <= 1'b0;
            show_time   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            start_q     <= start;
            delay       <= delay_nxt;
            target      <= target_nxt;
            timer_out   <= timer_nxt;
            miss_cnt    <= miss_nxt;
            false_start <= fs_nxt;
            show_time   <= (state_nxt == DONE);
            busy        <= (state_nxt == ARM) || (state_nxt == RUN);
            done        <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: per-cycle reference-model check, scenario table, corner-case sequences.
module tb_reaction_game_ctrl;

    localparam int DIV  = 10;
    localparam int PEN  = 50;
    localparam int DMIN = 2;
    localparam int TMAX = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [3:0]  target;
    logic [13:0] timer_out;
    logic        show_time;
    logic        busy;
    logic        done;
    logic        false_start;
    logic [3:0]  miss_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle 1=arm 2=run 3=done
    int          m_ph, m_pre, m_delay, m_timer, m_miss, m_fs, m_target;
    bit          m_sq;
    logic [15:0] m_lfsr;

    typedef struct {
        int ticks;
        int nwrong;
        int kind;
        int exp_timer;
        int exp_miss;
    } row_t;
    row_t rows[6];

    reaction_game_ctrl #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .PENALTY   (PEN),
        .DLY_MIN   (DMIN),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .target      (target),
        .timer_out   (timer_out),
        .show_time   (show_time),
        .busy        (busy),
        .done        (done),
        .false_start (false_start),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pre = 0; m_delay = 0; m_timer = 0; m_miss = 0; m_fs = 0;
        m_target = 0; m_sq = 1'b0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit s, input bit kv, input logic [3:0] kc);
        bit tk, rise;
        int ph0, t;
        tk   = (m_pre == DIV - 1);
        rise = s && !m_sq;
        ph0  = m_ph;
        case (m_ph)
            0, 3: if (rise) begin
                m_target = int'(m_lfsr[3:0]);
                m_delay  = DMIN + int'(m_lfsr[11:4]);
                m_timer  = 0; m_miss = 0; m_fs = 0; m_ph = 1;
            end
            1: if (kv) begin
                m_fs = 1; m_ph = 0;
            end else if (tk) begin
                m_delay--;
                if (m_delay <= 0) m_ph = 2;
            end
            2: if (kv && int'(kc) == m_target) begin
                m_ph = 3;
            end else begin
                t = m_timer + int'(tk) + (kv ? PEN : 0);
                m_timer = (t > TMAX) ? TMAX : t;
                if (kv && m_miss < 15) m_miss++;
            end
            default: m_ph = 0;
        endcase
        m_pre  = (m_ph != ph0 || tk) ? 0 : m_pre + 1;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_sq   = s;
    endtask

    task automatic check_all();
        check("target", 32'(target), 32'(m_target));
        check("timer_out", 32'(timer_out), 32'(m_timer));
        check("show_time", 32'(show_time), 32'(m_ph == 3));
        check("busy", 32'(busy), 32'(m_ph == 1 || m_ph == 2));
        check("done", 32'(done), 32'(m_ph == 3));
        check("false_start", 32'(false_start), 32'(m_fs));
        check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare away from it.
    task automatic step(input bit s, input bit kv, input logic [3:0] kc);
        start = s; key_valid = kv; key_code = kc;
        @(posedge clk);
        if (rst_n) model_step(s, kv, kc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0);
    endtask

    task automatic start_round();
        step(1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
    endtask

    task automatic wait_run_timer(input int n);
        int k;
        k = 0;
        while (!(m_ph == 2 && m_timer == n) && k < 6000) begin
            step(1'b0, 1'b0, 4'd0);
            k++;
        end
        if (!(m_ph == 2 && m_timer == n)) begin
            checks++; errors++;
            $display("FAIL wait_run: phase %0d timer %0d, required run with timer %0d", m_ph, m_timer, n);
        end
    endtask

    task automatic wait_arm_pre_tick();
        int k;
        k = 0;
        while (!(m_ph == 1 && m_pre == DIV - 1) && k < 100) begin
            step(1'b0, 1'b0, 4'd0);
            k++;
        end
        if (!(m_ph == 1 && m_pre == DIV - 1)) begin
            checks++; errors++;
            $display("FAIL wait_arm: phase %0d prescale %0d, required arm before tick", m_ph, m_pre);
        end
    endtask

    initial begin
        logic [3:0] wrong;
        bit         kv;
        logic [3:0] kc;

        rows[0] = '{37, 0, 0, 37, 0};
        rows[1] = '{10, 2, 0, 110, 2};
        rows[2] = '{0, 1, 0, 50, 1};
        rows[3] = '{5, 0, 1, 5, 0};
        rows[4] = '{10, 1, 2, 61, 1};
        rows[5] = '{20, 3, 1, 170, 3};

        // Reset state, then 1000 quiet cycles in idle
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        idle(1000);
        check("idle_busy", 32'(busy), 32'd0);

        // Scenario table: ticks before keys, wrong keys, timing kind
        for (int r = 0; r < 6; r++) begin
            start_round();
            wait_run_timer(rows[r].ticks);
            wrong = 4'(m_target) ^ 4'h1;
            case (rows[r].kind)
                0: begin
                    for (int i = 0; i < rows[r].nwrong; i++) step(1'b0, 1'b1, wrong);
                end
                1: begin
                    for (int i = 0; i < rows[r].nwrong; i++) step(1'b0, 1'b1, wrong);
                    idle(DIV - 1 - rows[r].nwrong);
                end
                default: begin
                    idle(DIV - rows[r].nwrong);
                    for (int i = 0; i < rows[r].nwrong; i++) step(1'b0, 1'b1, wrong);
                end
            endcase
            step(1'b0, 1'b1, 4'(m_target));
            check("row_timer", 32'(timer_out), 32'(rows[r].exp_timer));
            check("row_miss", 32'(miss_cnt), 32'(rows[r].exp_miss));
            check("row_done", 32'(done), 32'd1);
            check("row_show", 32'(show_time), 32'd1);
            idle(3);
        end

        // False start during arm, then the next start clears it
        start_round();
        idle(4);
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)));
        check("fs_flag", 32'(false_start), 32'd1);
        check("fs_busy", 32'(busy), 32'd0);
        check("fs_timer", 32'(timer_out), 32'd0);
        idle(30);
        check("fs_hold", 32'(false_start), 32'd1);
        start_round();
        check("fs_clear", 32'(false_start), 32'd0);
        check("fs_rearm", 32'(busy), 32'd1);

        // Key coincident with an arm tick is still a false start
        wait_arm_pre_tick();
        step(1'b0, 1'b1, 4'd3);
        check("fs_tick_flag", 32'(false_start), 32'd1);
        check("fs_tick_busy", 32'(busy), 32'd0);

        // Saturation of timer and miss count
        start_round();
        wait_run_timer(0);
        wrong = 4'(m_target) ^ 4'h8;
        for (int i = 0; i < 210; i++) step(1'b0, 1'b1, wrong);
        check("sat_timer", 32'(timer_out), 32'd9999);
        check("sat_miss", 32'(miss_cnt), 32'd15);
        idle(35);
        check("sat_hold", 32'(timer_out), 32'd9999);
        step(1'b0, 1'b1, 4'(m_target));
        check("sat_done", 32'(done), 32'd1);

        // Start ignored while running
        start_round();
        wait_run_timer(2);
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        check("run_start_ignored", 32'(busy), 32'd1);

        // Asynchronous reset mid-run
        idle(13);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("arst_timer", 32'(timer_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_target", 32'(target), 32'd0);
        check("arst_miss", 32'(miss_cnt), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            kv = ($urandom_range(0, 19) == 0);
            kc = ($urandom_range(0, 3) == 0) ? 4'(m_target) : 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 4, kv, kc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
